// File: rtl/fib_majority_stream.sv
// -----------------------------------------------------------------------------
// fib_majority_stream
//
// Collects frames of COUNT unsigned samples and reports whether more than half
// of them are Fibonacci numbers representable in WIDTH bits.
//
// Ports
//   clk, rst_n            clock, synchronous active-low reset
//   abort                 flush the current frame or drop a pending result
//   in_valid/in_ready     sample handshake, in_data carries the sample
//   out_valid/out_ready   result handshake
//   majority              frame hit count > COUNT/2
//   hit_count             Fibonacci hits in the last completed frame
//   sample_idx            samples accepted so far in the current frame
// -----------------------------------------------------------------------------
module fib_majority_stream #(
    parameter int WIDTH = 4,
    parameter int COUNT = 13,
    parameter int CW    = $clog2(COUNT + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             abort,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             majority,
    output logic [CW-1:0]    hit_count,
    output logic [CW-1:0]    sample_idx
);

    localparam int unsigned   MAXV = (32'd1 << WIDTH) - 32'd1;
    localparam logic [CW-1:0] LAST = CW'(COUNT - 1);
    localparam logic [CW-1:0] HALF = CW'((COUNT - 1) / 2);

    typedef enum logic {COLLECT, RESULT} state_t;

    state_t        state;
    logic          rdy;       // registered "in COLLECT and out of reset"
    logic [CW-1:0] run;       // running hit count of the open frame
    logic          hit;
    logic [CW-1:0] run_next;

    // Walk the Fibonacci sequence up to the largest WIDTH-bit value. 32 terms
    // comfortably exceed 2^16, the widest legal sample.
    function automatic logic is_fib(input logic [WIDTH-1:0] v);
        int unsigned a, b, t;
        logic        found;
        a     = 0;
        b     = 1;
        found = 1'b0;
        for (int i = 0; i < 32; i++) begin
            if (a <= MAXV && a == 32'(v)) found = 1'b1;
            t = a + b;
            a = b;
            b = t;
        end
        return found;
    endfunction

    assign hit       = is_fib(in_data);
    assign run_next  = run + CW'(hit);
    // Gated by rst_n so the port reads 0 through the whole reset window,
    // including the cycle before the first reset edge.
    assign in_ready  = rdy & rst_n;
    assign out_valid = (state == RESULT);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= COLLECT;
            rdy        <= 1'b0;
            majority   <= 1'b0;
            hit_count  <= '0;
            sample_idx <= '0;
            run        <= '0;
        end else begin
            case (state)
                COLLECT: begin
                    rdy <= 1'b1;
                    if (abort) begin
                        // abort beats a simultaneous sample
                        sample_idx <= '0;
                        run        <= '0;
                    end else if (in_valid && rdy) begin
                        if (sample_idx == LAST) begin
                            state      <= RESULT;
                            rdy        <= 1'b0;
                            hit_count  <= run_next;
                            majority   <= (run_next > HALF);
                            sample_idx <= '0;
                            run        <= '0;
                        end else begin
                            sample_idx <= sample_idx + CW'(1);
                            run        <= run_next;
                        end
                    end
                end
                RESULT: begin
                    if (abort) begin
                        state     <= COLLECT;
                        rdy       <= 1'b1;
                        majority  <= 1'b0;
                        hit_count <= '0;
                    end else if (out_ready) begin
                        state <= COLLECT;
                        rdy   <= 1'b1;
                    end
                end
                default: state <= COLLECT;
            endcase
        end
    end

endmodule

// File: tb/tb_fib_majority_stream.sv
module tb_fib_majority_stream;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    // main instance: WIDTH=4, COUNT=13
    logic       abort, in_valid, in_ready, out_valid, out_ready, majority;
    logic [3:0] in_data, hit_count, sample_idx;

    // WIDTH=8, COUNT=3
    logic       ab8, iv8, ir8, ov8, or8, mj8;
    logic [7:0] d8;
    logic [1:0] hc8, ix8;

    // WIDTH=16, COUNT=1
    logic        ab1, iv1, ir1, ov1, or1, mj1;
    logic [15:0] d1;
    logic        hc1, ix1;

    fib_majority_stream #(.WIDTH(4), .COUNT(13)) dut (
        .clk(clk), .rst_n(rst_n), .abort(abort), .in_valid(in_valid),
        .in_ready(in_ready), .in_data(in_data), .out_valid(out_valid),
        .out_ready(out_ready), .majority(majority), .hit_count(hit_count),
        .sample_idx(sample_idx));

    fib_majority_stream #(.WIDTH(8), .COUNT(3)) dut8 (
        .clk(clk), .rst_n(rst_n), .abort(ab8), .in_valid(iv8),
        .in_ready(ir8), .in_data(d8), .out_valid(ov8),
        .out_ready(or8), .majority(mj8), .hit_count(hc8),
        .sample_idx(ix8));

    fib_majority_stream #(.WIDTH(16), .COUNT(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .abort(ab1), .in_valid(iv1),
        .in_ready(ir1), .in_data(d1), .out_valid(ov1),
        .out_ready(or1), .majority(mj1), .hit_count(hc1),
        .sample_idx(ix1));

    int nerr = 0;
    int nchk = 0;

    typedef struct {
        int s[13];
        int hits;
        int maj;
    } vec_t;

    vec_t tbl[5];
    int   fr[13];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Reference membership test: n is Fibonacci iff 5n^2+4 or 5n^2-4 is a
    // perfect square.
    function automatic bit is_sq(input longint x);
        longint r;
        if (x < 0) return 1'b0;
        r = longint'($sqrt(real'(x)));
        for (longint k = r - 1; k <= r + 1; k++)
            if (k >= 0 && k * k == x) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit ref_fib(input longint n);
        return is_sq(5 * n * n + 4) || is_sq(5 * n * n - 4);
    endfunction

    // feed fr[] back to back, one sample per cycle
    task automatic send_frame();
        for (int i = 0; i < 13; i++) begin
            in_valid = 1'b1;
            in_data  = 4'(fr[i]);
            chk("idx_during_frame", 32'(sample_idx), i);
            chk("ready_during_frame", 32'(in_ready), 1);
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    // random-phase model state
    int q[$];
    bit m_pend;
    int m_hc, m_maj;

    initial begin
        rst_n = 1'b0; abort = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        ab8 = 1'b0; iv8 = 1'b0; d8 = '0; or8 = 1'b0;
        ab1 = 1'b0; iv1 = 1'b0; d1 = '0; or1 = 1'b0;

        tbl[0].s = '{0,1,2,3,5,8,13,4,6,7,9,10,11};      tbl[0].hits = 7;  tbl[0].maj = 1;
        tbl[1].s = '{1,2,3,5,8,13,4,6,7,9,10,11,12};     tbl[1].hits = 6;  tbl[1].maj = 0;
        tbl[2].s = '{default:0};                          tbl[2].hits = 13; tbl[2].maj = 1;
        tbl[3].s = '{default:15};                         tbl[3].hits = 0;  tbl[3].maj = 0;
        tbl[4].s = '{4,13,6,8,7,5,9,3,10,2,11,1,12};      tbl[4].hits = 6;  tbl[4].maj = 0;

        // ---- reset
        tick(); tick();
        chk("rst_in_ready", 32'(in_ready), 0);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_hit_count", 32'(hit_count), 0);
        chk("rst_majority", 32'(majority), 0);
        chk("rst_sample_idx", 32'(sample_idx), 0);
        rst_n = 1'b1;
        tick();
        chk("ready_after_rst", 32'(in_ready), 1);

        // ---- table-driven frames
        for (int k = 0; k < 5; k++) begin
            fr = tbl[k].s;
            send_frame();
            chk("tbl_out_valid", 32'(out_valid), 1);
            chk("tbl_hit_count", 32'(hit_count), tbl[k].hits);
            chk("tbl_majority", 32'(majority), tbl[k].maj);
            chk("tbl_idx_cleared", 32'(sample_idx), 0);
            chk("tbl_ready_low", 32'(in_ready), 0);
            handshake();
            chk("tbl_valid_drop", 32'(out_valid), 0);
            chk("tbl_ready_back", 32'(in_ready), 1);
            chk("tbl_hc_retained", 32'(hit_count), tbl[k].hits);
            chk("tbl_maj_retained", 32'(majority), tbl[k].maj);
        end

        // ---- stall in RESULT with in_valid held high
        fr = tbl[0].s;
        send_frame();
        in_valid = 1'b1;
        in_data  = 4'd1;
        for (int c = 0; c < 5; c++) begin
            tick();
            chk("stall_ready", 32'(in_ready), 0);
            chk("stall_valid", 32'(out_valid), 1);
            chk("stall_hc", 32'(hit_count), 7);
            chk("stall_idx", 32'(sample_idx), 0);
        end
        in_valid = 1'b0;
        handshake();
        chk("stall_release_valid", 32'(out_valid), 0);
        chk("stall_release_idx", 32'(sample_idx), 0);

        // ---- abort mid-frame together with a valid sample
        fr = '{1,4,2,6,3,7,5,9,0,0,0,0,0};
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_data  = 4'(fr[i]);
            tick();
        end
        chk("abort_pre_idx", 32'(sample_idx), 8);
        abort    = 1'b1;
        in_data  = 4'd8;
        tick();
        abort    = 1'b0;
        in_valid = 1'b0;
        chk("abort_idx", 32'(sample_idx), 0);
        chk("abort_no_result", 32'(out_valid), 0);
        fr = tbl[1].s;
        send_frame();
        chk("post_abort_hc", 32'(hit_count), 6);
        chk("post_abort_maj", 32'(majority), 0);
        handshake();

        // ---- abort in RESULT
        fr = tbl[0].s;
        send_frame();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_res_valid", 32'(out_valid), 0);
        chk("abort_res_maj", 32'(majority), 0);
        chk("abort_res_hc", 32'(hit_count), 0);
        chk("abort_res_ready", 32'(in_ready), 1);

        // ---- out_ready held high before RESULT: one-cycle out_valid
        out_ready = 1'b1;
        fr = tbl[2].s;
        send_frame();
        chk("early_rdy_valid", 32'(out_valid), 1);
        chk("early_rdy_hc", 32'(hit_count), 13);
        tick();
        chk("early_rdy_drop", 32'(out_valid), 0);
        chk("early_rdy_ready", 32'(in_ready), 1);
        out_ready = 1'b0;

        // ---- reset while in RESULT with majority=1
        fr = tbl[0].s;
        send_frame();
        chk("pre_rst_maj", 32'(majority), 1);
        rst_n = 1'b0;
        tick();
        chk("rst_res_valid", 32'(out_valid), 0);
        chk("rst_res_maj", 32'(majority), 0);
        chk("rst_res_hc", 32'(hit_count), 0);
        chk("rst_res_idx", 32'(sample_idx), 0);
        chk("rst_res_ready", 32'(in_ready), 0);
        rst_n = 1'b1;
        tick();
        chk("rst_res_ready_back", 32'(in_ready), 1);

        // ---- randomized traffic against a transaction-level model
        m_pend = 1'b0; m_hc = 0; m_maj = 0; q.delete();
        for (int c = 0; c < 800; c++) begin
            int h;
            chk("rnd_out_valid", 32'(out_valid), 32'(m_pend));
            chk("rnd_in_ready", 32'(in_ready), 32'(!m_pend));
            chk("rnd_idx", 32'(sample_idx), q.size());
            chk("rnd_hc", 32'(hit_count), m_hc);
            chk("rnd_maj", 32'(majority), m_maj);
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = 4'($urandom);
            out_ready = ($urandom_range(0, 2) == 0);
            abort     = ($urandom_range(0, 40) == 0);
            if (!m_pend) begin
                if (abort) q.delete();
                else if (in_valid) begin
                    q.push_back(int'(in_data));
                    if (q.size() == 13) begin
                        h = 0;
                        foreach (q[j]) if (ref_fib(q[j])) h++;
                        m_hc  = h;
                        m_maj = (2 * h > 13) ? 1 : 0;
                        q.delete();
                        m_pend = 1'b1;
                    end
                end
            end else begin
                if (abort) begin
                    m_pend = 1'b0; m_hc = 0; m_maj = 0;
                end else if (out_ready) m_pend = 1'b0;
            end
            tick();
        end
        in_valid = 1'b0; out_ready = 1'b0; abort = 1'b0;

        // ---- WIDTH=8, COUNT=3
        begin
            int a8[6];
            int e8h[2];
            int e8m[2];
            a8 = '{144, 233, 200, 200, 255, 21};
            e8h = '{2, 1};
            e8m = '{1, 0};
            for (int f = 0; f < 2; f++) begin
                for (int i = 0; i < 3; i++) begin
                    iv8 = 1'b1;
                    d8  = 8'(a8[3*f+i]);
                    chk("w8_ready", 32'(ir8), 1);
                    tick();
                end
                iv8 = 1'b0;
                chk("w8_valid", 32'(ov8), 1);
                chk("w8_hc", 32'(hc8), e8h[f]);
                chk("w8_maj", 32'(mj8), e8m[f]);
                or8 = 1'b1;
                tick();
                or8 = 1'b0;
                chk("w8_drop", 32'(ov8), 0);
            end
        end

        // ---- WIDTH=16, COUNT=1: each sample is a frame
        begin
            int s1[4];
            int e1[4];
            s1 = '{46368, 46369, 65535, 0};
            e1 = '{1, 0, 0, 1};
            for (int i = 0; i < 4; i++) begin
                iv1 = 1'b1;
                d1  = 16'(s1[i]);
                chk("w16_ready", 32'(ir1), 1);
                tick();
                iv1 = 1'b0;
                chk("w16_valid", 32'(ov1), 1);
                chk("w16_hc", 32'(hc1), e1[i]);
                chk("w16_maj", 32'(mj1), e1[i]);
                chk("w16_idx", 32'(ix1), 0);
                or1 = 1'b1;
                tick();
                or1 = 1'b0;
                chk("w16_drop", 32'(ov1), 0);
            end
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

// File: doc/fib_majority_stream.md
FIB_MAJORITY_STREAM -- requirements
Module: fib_majority_stream

Interface
REQ-001 Parameter WIDTH, default 4, sample bit width; legal range 2..16.
REQ-002 Parameter COUNT, default 13, samples per frame; legal range 1..255, odd values only.
REQ-003 Parameter CW, default $clog2(COUNT+1), width of the hit counter; derived, not overridden.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  reset, synchronous and active-low.
REQ-006 abort  input  1  synchronous frame flush; ignored while rst_n=0.
REQ-007 in_valid  input  1  in_data holds a sample.
REQ-008 in_ready  output  1  block accepts a sample this cycle.
REQ-009 in_data  input  WIDTH  unsigned sample.
REQ-010 out_valid  output  1  frame result available.
REQ-011 out_ready  input  1  consumer takes the result this cycle.
REQ-012 majority  output  1  1 when the frame's Fibonacci hits exceed COUNT/2.
REQ-013 hit_count  output  CW  number of Fibonacci samples in the completed frame.
REQ-014 sample_idx  output  CW  samples accepted so far in the current frame.

Function
REQ-015 Fibonacci membership is combinational: in_data is a hit iff it equals a Fibonacci number (0,1,2,3,5,8,13,21,34,55,89,144,233,...) that is at most 2^WIDTH-1. The set is generated from WIDTH, not from a fixed table.
REQ-016 The FSM has two states, COLLECT and RESULT. Reset enters COLLECT.
REQ-017 COLLECT: in_ready=1 and out_valid=0. A sample is accepted when in_valid=1 and in_ready=1 in the same cycle.
REQ-018 Each accepted sample increments sample_idx by 1. It also increments the hit counter by 1 when the sample is a Fibonacci value.
REQ-019 On acceptance of sample number COUNT, the block moves to RESULT on the next edge.
REQ-019 (cont.) In that same edge it registers hit_count (including the last sample) and majority = (hit_count > (COUNT-1)/2). It also clears sample_idx and the running hit counter to 0.
REQ-020 Latency: out_valid rises exactly one cycle after the cycle that accepted the last sample.
REQ-021 RESULT: out_valid=1 and in_ready=0. majority and hit_count stay stable until the handshake completes.
REQ-022 RESULT handshake: when out_valid=1 and out_ready=1, the block returns to COLLECT on the next edge and out_valid drops to 0. in_ready=1 in the following cycle, so there is one bubble cycle per frame.
REQ-023 If out_ready is held at 1 before RESULT is entered, the result is consumed in its first RESULT cycle. out_valid is then high for exactly one cycle.
REQ-024 majority and hit_count keep their last frame's value after the handshake until the next frame completes. They are 0 before the first frame completes.
REQ-025 abort=1 in COLLECT: sample_idx and the running hit count clear to 0 on the next edge. Any sample presented in the same cycle is discarded (abort wins over acceptance). The FSM stays in COLLECT.
REQ-026 abort=1 in RESULT: the pending result is dropped. The block returns to COLLECT with out_valid=0 on the next edge, and majority and hit_count clear to 0.
REQ-027 COUNT=1: every accepted sample produces a result. majority equals that sample's Fibonacci membership.
REQ-028 The hit counter cannot overflow, because CW covers 0..COUNT.

Reset
REQ-029 When rst_n=0 at a rising edge, the next state is COLLECT. All of these are 0: out_valid, majority, hit_count, sample_idx, and the running hit counter.
REQ-030 in_ready is 0 in every cycle where rst_n=0.
REQ-031 in_ready becomes 1 in the first cycle after rst_n is sampled high.
REQ-032 Reset asserted mid-frame or during RESULT discards all partial and pending data with no result emitted.

Verification (WIDTH=4, COUNT=13 unless stated)
REQ-033 Stream 0,1,2,3,5,8,13,4,6,7,9,10,11 back-to-back -> one cycle later out_valid=1, hit_count=7, majority=1.
REQ-034 Stream 1,2,3,5,8,13,4,6,7,9,10,11,12 -> hit_count=6, majority=0.
REQ-035 Hold out_ready=0 for 5 cycles in RESULT while in_valid=1 -> in_ready=0 throughout, the result is held stable and no samples are accepted; then out_ready=1 -> back in COLLECT after one edge with sample_idx=0.
REQ-036 Assert abort after 8 samples (4 hits) in the same cycle as a valid sample -> sample_idx=0 and that sample is dropped; the next 13 samples alone determine hit_count.
REQ-037 WIDTH=8, COUNT=3, samples 144,233,200 -> hit_count=2, majority=1. Samples 200,255,21 -> hit_count=1, majority=0.
REQ-038 rst_n=0 while in RESULT with majority=1 -> the next cycle shows out_valid=0, majority=0, hit_count=0, sample_idx=0.
